// File: rtl/mux_sel_arbiter_pkg.sv
// mux_sel_arbiter_pkg: state encodings and default widths shared by the arbiter files
package mux_sel_arbiter_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT   = 2'b01,
        RELEASE = 2'b10
    } state_t;
    localparam int DEF_NREQ     = 4;
    localparam int DEF_SELW     = 2;
    localparam int DEF_MAX_HOLD = 16;
    localparam int DEF_CNTW     = 4;
endpackage

// File: rtl/mux_sel_arbiter_rr_pick.sv
// mux_sel_arbiter_rr_pick: first set request at or after ptr, searching cyclically
module mux_sel_arbiter_rr_pick
    import mux_sel_arbiter_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int SELW = DEF_SELW
) (
    input  logic [NREQ-1:0] req,
    input  logic [SELW-1:0] ptr,
    output logic            found,
    output logic [SELW-1:0] idx
);
    int j;
    always_comb begin
        found = |req;
        idx = '0;
        j = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            j = (j >= NREQ) ? j - NREQ : j;
            if (req[j]) idx = SELW'(j);
        end
    end
endmodule

// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: round-robin arbiter driving the 4:1 data mux select with a bounded hold time
module mux_sel_arbiter
    import mux_sel_arbiter_pkg::*;
#(
    parameter int NREQ     = DEF_NREQ,
    parameter int SELW     = DEF_SELW,
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int CNTW     = DEF_CNTW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            done,
    output logic [NREQ-1:0] grant,
    output logic [SELW-1:0] sel,
    output logic            busy,
    output logic            timeout
);
    state_t          state;
    logic [SELW-1:0] ptr;
    logic [CNTW-1:0] hold_cnt;
    logic            found;
    logic [SELW-1:0] pick_idx;
    logic            cnt_hit;
    logic            rel;
    logic [SELW-1:0] ptr_nxt;

    mux_sel_arbiter_rr_pick #(.NREQ(NREQ), .SELW(SELW)) u_pick (
        .req  (req),
        .ptr  (ptr),
        .found(found),
        .idx  (pick_idx)
    );

    always_comb begin
        cnt_hit = hold_cnt == CNTW'(MAX_HOLD - 1);
        rel     = done || !req[sel] || cnt_hit;
        ptr_nxt = (sel == SELW'(NREQ - 1)) ? '0 : sel + SELW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            sel      <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                GRANT: begin
                    if (rel) begin
                        grant   <= '0;
                        busy    <= 1'b0;
                        ptr     <= ptr_nxt;
                        state   <= RELEASE;
                        // an explicit done or a dropped request takes precedence over the limit
                        timeout <= cnt_hit && !done && req[sel];
                    end else begin
                        hold_cnt <= hold_cnt + CNTW'(1);
                    end
                end
                RELEASE: state <= IDLE;
                default: begin
                    if (found) begin
                        grant    <= NREQ'(1) << pick_idx;
                        sel      <= pick_idx;
                        busy     <= 1'b1;
                        hold_cnt <= '0;
                        state    <= GRANT;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb_mux_sel_arbiter: directed cycle-by-cycle checks of grant/sel/busy/timeout via an expectation queue
module tb_mux_sel_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;

    logic [7:0] exp_q[$];
    string      tag_q[$];
    int         n_checks = 0;
    int         n_fail = 0;

    mux_sel_arbiter #(.NREQ(4), .SELW(2), .MAX_HOLD(16), .CNTW(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .done   (done),
        .grant  (grant),
        .sel    (sel),
        .busy   (busy),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic rs, input logic [3:0] r, input logic d,
                       input logic [3:0] eg, input logic [1:0] es,
                       input logic eb, input logic et, input string tag);
        logic [7:0] e;
        logic [7:0] got;
        string      t;
        rst  = rs;
        req  = r;
        done = d;
        exp_q.push_back({eg, es, eb, et});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        got = {grant, sel, busy, timeout};
        n_checks++;
        assert (got === e) else begin
            n_fail++;
            $error("FAIL %s: grant/sel/busy/timeout got %b/%0d/%b/%b expected %b/%0d/%b/%b",
                   t, got[7:4], got[3:2], got[1], got[0], e[7:4], e[3:2], e[1], e[0]);
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; done = 1'b0;
        cyc(1, 4'b1111, 0, 4'b0000, 0, 0, 0, "reset0");
        cyc(1, 4'b1111, 0, 4'b0000, 0, 0, 0, "reset1");
        for (int i = 0; i < 5; i++) begin
            cyc(0, 4'b1111, 0, 4'b0001 << (i % 4), 2'(i % 4), 1, 0, "fair_grant");
            cyc(0, 4'b1111, 1, 4'b0000, 2'(i % 4), 0, 0, "fair_release");
            cyc(0, (i == 4) ? 4'b0000 : 4'b1111, 0, 4'b0000, 2'(i % 4), 0, 0, "fair_dead");
        end
        cyc(0, 4'b0100, 0, 4'b0100, 2, 1, 0, "single_grant");
        cyc(0, 4'b0100, 1, 4'b0000, 2, 0, 0, "single_release");
        cyc(0, 4'b0000, 0, 4'b0000, 2, 0, 0, "single_dead");
        cyc(0, 4'b0000, 0, 4'b0000, 2, 0, 0, "idle_sel_hold");
        cyc(0, 4'b0010, 0, 4'b0010, 1, 1, 0, "to_grant");
        for (int i = 0; i < 15; i++)
            cyc(0, 4'b0010, 0, 4'b0010, 1, 1, 0, "to_hold");
        cyc(0, 4'b0010, 0, 4'b0000, 1, 0, 1, "to_pulse");
        cyc(0, 4'b0010, 0, 4'b0000, 1, 0, 0, "to_dead");
        cyc(0, 4'b0010, 0, 4'b0010, 1, 1, 0, "to_regrant");
        cyc(0, 4'b0010, 1, 4'b0000, 1, 0, 0, "to_regrant_rel");
        cyc(0, 4'b0110, 0, 4'b0000, 1, 0, 0, "to_dead2");
        cyc(0, 4'b0110, 0, 4'b0100, 2, 1, 0, "to_next_ch2");
        cyc(0, 4'b0110, 1, 4'b0000, 2, 0, 0, "ch2_release");
        cyc(0, 4'b1000, 0, 4'b0000, 2, 0, 0, "ch2_dead");
        cyc(0, 4'b1000, 0, 4'b1000, 3, 1, 0, "drop_grant");
        cyc(0, 4'b1000, 0, 4'b1000, 3, 1, 0, "drop_hold");
        cyc(0, 4'b0000, 0, 4'b0000, 3, 0, 0, "drop_release");
        cyc(0, 4'b0000, 0, 4'b0000, 3, 0, 0, "drop_dead");
        cyc(0, 4'b0001, 0, 4'b0001, 0, 1, 0, "sim_grant");
        for (int i = 0; i < 15; i++)
            cyc(0, 4'b0001, 0, 4'b0001, 0, 1, 0, "sim_hold");
        cyc(0, 4'b0001, 1, 4'b0000, 0, 0, 0, "sim_done_at_limit");
        cyc(0, 4'b0000, 0, 4'b0000, 0, 0, 0, "sim_dead");
        cyc(0, 4'b0000, 1, 4'b0000, 0, 0, 0, "done_in_idle");
        cyc(0, 4'b0100, 0, 4'b0100, 2, 1, 0, "mid_grant");
        cyc(0, 4'b0100, 0, 4'b0100, 2, 1, 0, "mid_hold");
        cyc(1, 4'b0100, 0, 4'b0000, 0, 0, 0, "reset_mid_grant");
        cyc(0, 4'b1001, 0, 4'b0001, 0, 1, 0, "post_reset_ptr0");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
